// File: rtl/encode_interp_multi.sv
// encode_interp_multi: N-channel encoder interpolator with modulo wrap, wafer-zero, interval and stale detection
module encode_interp_multi #(
  parameter real TCQ = 0.1,
  parameter int NUM_CH = 2,
  parameter int ENCODE_WID = 20,
  parameter int ENCODE_MASK_WID = 18,
  parameter logic [NUM_CH-1:0] WRAP_EN = 2'b01,
  parameter int INTER_LOG2 = 12,
  parameter int INTER_TOL = 8,
  parameter int TIMEOUT = 16384,
  parameter int OUT_DIV = 4,
  parameter logic [NUM_CH*ENCODE_WID-1:0] FIRST_DELTA = {20'd12, 20'd8192}
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         mode_i,
  input  logic                         encode_update_i,
  input  logic [NUM_CH*ENCODE_WID-1:0] encode_pos_i,
  output logic                         precise_encode_en_o,
  output logic [NUM_CH*ENCODE_WID-1:0] precise_encode_o,
  output logic                         wafer_zero_flag_o,
  output logic                         encode_valid_o,
  output logic                         interval_err_o,
  output logic [1:0]                   state_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, SEED = 2'd1, TRACK = 2'd2, STALE = 2'd3} state_t;
  localparam int EW = ENCODE_WID;
  localparam int M = ENCODE_MASK_WID;
  localparam int L = INTER_LOG2;
  localparam int AW = EW + L + 1;
  localparam int IW = ($clog2(TIMEOUT + 1) > L + 2) ? $clog2(TIMEOUT + 1) : L + 2;
  localparam int CW = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;
  localparam int LO = (1 << L) - INTER_TOL;
  localparam int HI = (1 << L) + INTER_TOL;
  localparam logic [EW-1:0] MSK = EW'((64'd1 << M) - 64'd1);
  localparam logic [M-1:0] Q1 = M'(64'd1 << (M - 2));
  localparam logic [M-1:0] Q3 = M'(64'd3 << (M - 2));

  state_t state_q, state_d;
  logic [IW-1:0] ic_q, ic_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stb_q, stb_d, en_q, en_d, wz_q, wz_d, err_q, err_d, have_q, have_d;
  logic [NUM_CH*EW-1:0] interp_all, out_q, out_d;
  logic live, live_d;
  logic [M-1:0] prev0, next0;

  assign live = (state_q == SEED) || (state_q == TRACK);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [EW-1:0] pos, base_q, base_d, delta_q, delta_d, interp_q, interp_d;
    logic signed [AW-1:0] acc_q, acc_d, dx, lim, sum;
    assign pos = encode_pos_i[c*EW +: EW];
    assign dx = {{(L + 1){delta_q[EW-1]}}, delta_q};
    assign lim = dx <<< L;
    assign sum = acc_q + dx;
    // Capture base/delta on update; otherwise ramp the accumulator and clamp at the predicted end point
    always_comb begin
      base_d = encode_update_i ? pos : base_q;
      delta_d = (encode_update_i && state_q != IDLE) ? pos - base_q : delta_q;
      acc_d = encode_update_i ? '0 :
              !(live && mode_i) ? acc_q :
              dx[AW-1] ? ((sum < lim) ? lim : sum) : ((sum > lim) ? lim : sum);
      interp_d = ((mode_i && state_q != STALE) ? base_q + acc_q[L +: EW] : base_q) & (WRAP_EN[c] ? MSK : '1);
    end
    // Per-channel state registers
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        base_q <= '0;
        delta_q <= FIRST_DELTA[c*EW +: EW];
        acc_q <= '0;
        interp_q <= '0;
      end else begin
        base_q <= base_d;
        delta_q <= delta_d;
        acc_q <= acc_d;
        interp_q <= interp_d;
      end
    end
    assign interp_all[c*EW +: EW] = interp_q;
  end

  // Next state, interval/strobe counters, output strobe pipeline and pulse flags
  always_comb begin
    state_d = state_q;
    if (encode_update_i) state_d = live ? TRACK : SEED;
    else if (live && ic_q >= IW'(TIMEOUT - 1)) state_d = STALE;
    live_d = (state_d == SEED) || (state_d == TRACK);
    ic_d = encode_update_i ? '0 : (ic_q == IW'(TIMEOUT)) ? ic_q : ic_q + 1'b1;
    cnt_d = (encode_update_i || cnt_q == CW'(OUT_DIV - 1)) ? '0 : cnt_q + 1'b1;
    stb_d = live && !encode_update_i && cnt_q == '0;
    en_d = stb_q && live_d;
    out_d = en_d ? interp_all : out_q;
    prev0 = out_q[M-1:0];
    next0 = interp_all[M-1:0];
    wz_d = WRAP_EN[0] && en_d && have_q && ((prev0 > Q3 && next0 < Q1) || (prev0 < Q1 && next0 > Q3));
    have_d = have_q || en_d;
    err_d = encode_update_i && state_q == TRACK && (int'(ic_q) + 1 < LO || int'(ic_q) + 1 > HI);
  end

  // Shared control and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ic_q <= '0;
      cnt_q <= '0;
      stb_q <= 1'b0;
      en_q <= 1'b0;
      wz_q <= 1'b0;
      err_q <= 1'b0;
      have_q <= 1'b0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      ic_q <= ic_d;
      cnt_q <= cnt_d;
      stb_q <= stb_d;
      en_q <= en_d;
      wz_q <= wz_d;
      err_q <= err_d;
      have_q <= have_d;
      out_q <= out_d;
    end
  end

  assign precise_encode_en_o = en_q;
  assign precise_encode_o = out_q;
  assign wafer_zero_flag_o = wz_q;
  assign encode_valid_o = live;
  assign interval_err_o = err_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_encode_interp_multi.sv
// tb_encode_interp_multi: directed checks of seeding, tracking, interval errors, wrap, timeout and raw mode
module tb_encode_interp_multi;
  logic clk, rst, mode, upd;
  logic [39:0] pos;
  logic en, wz, val, err, en4, wz4, val4, err4;
  logic [39:0] pe, pe4;
  logic [1:0] st, st4;
  int nvec, nerr, nwz;

  encode_interp_multi #(.INTER_LOG2(4), .INTER_TOL(8), .TIMEOUT(64), .OUT_DIV(1)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .encode_update_i(upd), .encode_pos_i(pos),
    .precise_encode_en_o(en), .precise_encode_o(pe), .wafer_zero_flag_o(wz),
    .encode_valid_o(val), .interval_err_o(err), .state_o(st));

  encode_interp_multi #(.INTER_LOG2(4), .INTER_TOL(8), .TIMEOUT(64), .OUT_DIV(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .encode_update_i(upd), .encode_pos_i(pos),
    .precise_encode_en_o(en4), .precise_encode_o(pe4), .wafer_zero_flag_o(wz4),
    .encode_valid_o(val4), .interval_err_o(err4), .state_o(st4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [19:0] p1, input logic [19:0] p0);
    pos = {p1, p0};
    upd = 1'b1;
    tick;
    upd = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    mode = 1'b1;
    upd = 1'b0;
    pos = '0;
    tick;
    tick;
    chk("rst_state", st, 0);
    chk("rst_en", en, 0);
    chk("rst_out", pe, 0);
    chk("rst_valid", val, 0);
    chk("rst_wz", wz, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    pulse(20'd2000, 20'd2000);
    chk("seed_state", st, 1);
    chk("seed_valid", val, 1);
    tick;
    chk("seed_en_lat1", en, 0);
    tick;
    chk("seed_en_lat2", en, 1);
    chk("seed_out0", pe[19:0], 2000);
    chk("seed_out1", pe[39:20], 2000);
    tick;
    chk("seed_ramp0", pe[19:0], 2512);
    chk("seed_ramp1", pe[39:20], 2000);
    repeat (12) tick;
    chk("seed_ramp0_late", pe[19:0], 8656);
    pulse(20'd2012, 20'd6096);
    chk("track_state", st, 2);
    chk("track_err_seed", err, 0);
    tick;
    tick;
    chk("track_out0", pe[19:0], 6096);
    chk("track_out1", pe[39:20], 2012);
    tick;
    tick;
    chk("track_ramp0", pe[19:0], 6608);
    chk("track_ramp1", pe[39:20], 2013);
    repeat (11) tick;
    pulse(20'd2024, 20'd10192);
    chk("track_err_ok", err, 0);
    repeat (20) tick;
    chk("late_hold0", pe[19:0], 14288);
    chk("late_hold1", pe[39:20], 2036);
    repeat (9) tick;
    chk("late_hold0_end", pe[19:0], 14288);
    pulse(20'd2030, 20'd16000);
    chk("late_err", err, 1);
    tick;
    chk("late_err_pulse", err, 0);
    tick;
    chk("late_snap0", pe[19:0], 16000);
    chk("late_snap1", pe[39:20], 2030);
    tick;
    tick;
    pulse(20'd2040, 20'd17000);
    chk("early_err", err, 1);
    tick;
    tick;
    chk("early_snap0", pe[19:0], 17000);
    chk("early_snap1", pe[39:20], 2040);
    rst = 1'b1;
    tick;
    chk("mid_rst_state", st, 0);
    chk("mid_rst_en", en, 0);
    chk("mid_rst_out", pe, 0);
    chk("mid_rst_valid", val, 0);
    rst = 1'b0;
    nwz = 0;
    pulse(20'd0, 20'd262000);
    for (int k = 1; k <= 70; k++) begin
      tick;
      nwz += int'(wz);
      if (k == 2) begin
        chk("fwd_base0", pe[19:0], 262000);
        chk("fwd_wz_base", wz, 0);
      end
      if (k == 3) begin
        chk("fwd_wrap0", pe[19:0], 368);
        chk("fwd_wz", wz, 1);
      end
      if (k == 4) chk("fwd_wz_once", wz, 0);
      if (k == 18) begin
        chk("fwd_sat0", pe[19:0], 8048);
        chk("fwd_sat1", pe[39:20], 12);
      end
      if (k == 63) chk("tmo_before", st, 1);
      if (k == 64) begin
        chk("tmo_state", st, 3);
        chk("tmo_valid", val, 0);
        chk("tmo_en", en, 0);
        chk("tmo_hold0", pe[19:0], 8048);
      end
      if (k == 65) chk("stale_en", en, 0);
      if (k == 70) begin
        chk("stale_hold0", pe[19:0], 8048);
        chk("stale_hold1", pe[39:20], 12);
      end
    end
    chk("fwd_wz_count", nwz, 1);
    pulse(20'd172, 20'd263600);
    chk("reseed_state", st, 1);
    chk("reseed_valid", val, 1);
    tick;
    tick;
    chk("reseed_en", en, 1);
    chk("reseed_out0", pe[19:0], 1456);
    chk("reseed_out1", pe[39:20], 172);
    chk("reseed_wz", wz, 0);
    tick;
    chk("reseed_ramp0", pe[19:0], 1556);
    chk("reseed_ramp1", pe[39:20], 182);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    pulse(20'd0, 20'd11192);
    repeat (15) tick;
    pulse(20'd0, 20'd3000);
    chk("rev_state", st, 2);
    nwz = 0;
    for (int k = 1; k <= 40; k++) begin
      tick;
      nwz += int'(wz);
      if (k == 2) chk("rev_base0", pe[19:0], 3000);
      if (k == 7) begin
        chk("rev_pre0", pe[19:0], 440);
        chk("rev_pre_wz", wz, 0);
      end
      if (k == 8) begin
        chk("rev_wrap0", pe[19:0], 262072);
        chk("rev_wz", wz, 1);
      end
      if (k == 18) chk("rev_sat0", pe[19:0], 256952);
      if (k == 40) chk("rev_hold0", pe[19:0], 256952);
    end
    chk("rev_wz_count", nwz, 1);
    mode = 1'b0;
    pulse(20'd7000, 20'd5000);
    chk("raw_err", err, 1);
    chk("raw_state", st, 2);
    for (int k = 1; k <= 12; k++) begin
      tick;
      chk("raw_en4", en4, (k >= 2 && (k - 2) % 4 == 0));
      if (k == 2) chk("raw_out4_first", pe4, {20'd7000, 20'd5000});
      if (k == 5) chk("raw_out", pe, {20'd7000, 20'd5000});
      if (k == 6) chk("raw_out4_second", pe4, {20'd7000, 20'd5000});
      if (k == 12) chk("raw_out4_hold", pe4, {20'd7000, 20'd5000});
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
